// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall detection and flush; 1-cycle ID->EX latency.
// Backpressure: id_ready drops while EX holds (ex_ready=0), on a load-use hazard, or during flush.
module id_ex_stage (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               id_valid,
   output logic               id_ready,
   input  logic [5:0]         id_alu_control,
   input  logic [31:0]        id_pc,
   input  logic [31:0]        id_rs1_data,
   input  logic [31:0]        id_rs2_data,
   input  logic [31:0]        id_imm,
   input  logic [4:0]         id_rs1_addr,
   input  logic [4:0]         id_rs2_addr,
   input  logic [4:0]         id_rd_addr,
   input  logic               id_use_pc,
   input  logic               id_use_imm,
   input  logic               id_reg_write,
   input  logic               id_mem_read,
   input  logic               id_mem_write,
   input  logic               mem_fwd_en,
   input  logic [4:0]         mem_fwd_rd,
   input  logic [31:0]        mem_fwd_data,
   input  logic               wb_fwd_en,
   input  logic [4:0]         wb_fwd_rd,
   input  logic [31:0]        wb_fwd_data,
   input  logic               ex_ready,
   input  logic               flush,
   output logic               ex_valid,
   output logic [5:0]         ex_alu_control,
   output logic signed [31:0] operand_A,
   output logic signed [31:0] operand_B,
   output logic [31:0]        ex_store_data,
   output logic [31:0]        ex_pc,
   output logic [4:0]         ex_rd_addr,
   output logic               ex_reg_write,
   output logic               ex_mem_read,
   output logic               ex_mem_write,
   output logic [15:0]        lu_stall_cnt
);

   typedef struct packed {
      logic [5:0]  alu_control;
      logic [31:0] pc;
      logic [31:0] rs1_val;
      logic [31:0] rs2_val;
      logic [31:0] imm;
      logic [4:0]  rs1_addr;
      logic [4:0]  rs2_addr;
      logic [4:0]  rd_addr;
      logic        use_pc;
      logic        use_imm;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
   } ex_entry_t;

   typedef enum logic {RUN, LU_STALL} state_t;

   ex_entry_t   ex_q, ex_d;
   logic        ex_valid_q, ex_valid_d;
   state_t      state_q, state_d;
   logic [15:0] lu_stall_cnt_q, lu_stall_cnt_d;

   logic        advance;
   logic        load_use;
   logic        transfer;
   logic [31:0] fwd_rs1;
   logic [31:0] fwd_rs2;

   // x0 is hardwired zero; the younger MEM producer wins over WB.
   function automatic logic [31:0] fwd(input logic [31:0] r, input logic [4:0] addr,
                                       input logic m_en, input logic [4:0] m_rd, input logic [31:0] m_dat,
                                       input logic w_en, input logic [4:0] w_rd, input logic [31:0] w_dat);
      logic [31:0] v;
      if (addr == 5'd0)
         v = 32'd0;
      else if (m_en && m_rd == addr)
         v = m_dat;
      else if (w_en && w_rd == addr)
         v = w_dat;
      else
         v = r;
      return v;
   endfunction

   always_comb begin
      advance  = !ex_valid_q || ex_ready;
      load_use = ex_valid_q && ex_q.mem_read && (ex_q.rd_addr != 5'd0) &&
                 ((id_rs1_addr == ex_q.rd_addr) || (id_rs2_addr == ex_q.rd_addr));
      id_ready = advance && !load_use && !flush;
      transfer = id_valid && id_ready;
      fwd_rs1  = fwd(ex_q.rs1_val, ex_q.rs1_addr, mem_fwd_en, mem_fwd_rd, mem_fwd_data,
                     wb_fwd_en, wb_fwd_rd, wb_fwd_data);
      fwd_rs2  = fwd(ex_q.rs2_val, ex_q.rs2_addr, mem_fwd_en, mem_fwd_rd, mem_fwd_data,
                     wb_fwd_en, wb_fwd_rd, wb_fwd_data);
   end

   always_comb begin
      ex_d       = ex_q;
      ex_valid_d = ex_valid_q;
      if (flush) begin
         ex_valid_d = 1'b0;
      end else if (advance) begin
         ex_valid_d = transfer;
         if (transfer) begin
            ex_d.alu_control = id_alu_control;
            ex_d.pc          = id_pc;
            ex_d.rs1_val     = id_rs1_data;
            ex_d.rs2_val     = id_rs2_data;
            ex_d.imm         = id_imm;
            ex_d.rs1_addr    = id_rs1_addr;
            ex_d.rs2_addr    = id_rs2_addr;
            ex_d.rd_addr     = id_rd_addr;
            ex_d.use_pc      = id_use_pc;
            ex_d.use_imm     = id_use_imm;
            ex_d.reg_write   = id_reg_write;
            ex_d.mem_read    = id_mem_read;
            ex_d.mem_write   = id_mem_write;
         end
      end else begin
         // Capture forwarded operands while stalled so they survive producer retirement.
         ex_d.rs1_val = fwd_rs1;
         ex_d.rs2_val = fwd_rs2;
      end
   end

   always_comb begin
      state_d        = state_q;
      lu_stall_cnt_d = lu_stall_cnt_q;
      if (flush) begin
         state_d = RUN;
      end else begin
         case (state_q)
            RUN:      if (load_use && advance) state_d = LU_STALL;
            LU_STALL: state_d = RUN;
            default:  state_d = RUN;
         endcase
      end
      if (state_q == RUN && state_d == LU_STALL && lu_stall_cnt_q != 16'hFFFF)
         lu_stall_cnt_d = lu_stall_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q           <= '0;
         ex_valid_q     <= 1'b0;
         state_q        <= RUN;
         lu_stall_cnt_q <= 16'd0;
      end else begin
         ex_q           <= ex_d;
         ex_valid_q     <= ex_valid_d;
         state_q        <= state_d;
         lu_stall_cnt_q <= lu_stall_cnt_d;
      end
   end

   assign ex_valid       = ex_valid_q;
   assign ex_alu_control = ex_q.alu_control;
   assign operand_A      = ex_q.use_pc  ? ex_q.pc  : fwd_rs1;
   assign operand_B      = ex_q.use_imm ? ex_q.imm : fwd_rs2;
   assign ex_store_data  = fwd_rs2;
   assign ex_pc          = ex_q.pc;
   assign ex_rd_addr     = ex_q.rd_addr;
   assign ex_reg_write   = ex_valid_q && ex_q.reg_write;
   assign ex_mem_read    = ex_valid_q && ex_q.mem_read;
   assign ex_mem_write   = ex_valid_q && ex_q.mem_write;
   assign lu_stall_cnt   = lu_stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, transfer, forwarding, hold refresh, load-use, flush, saturation, async reset.
module tb_id_ex_stage;
   logic               clk;
   logic               rst_n;
   logic               id_valid;
   logic               id_ready;
   logic [5:0]         id_alu_control;
   logic [31:0]        id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]         id_rs1_addr, id_rs2_addr, id_rd_addr;
   logic               id_use_pc, id_use_imm, id_reg_write, id_mem_read, id_mem_write;
   logic               mem_fwd_en;
   logic [4:0]         mem_fwd_rd;
   logic [31:0]        mem_fwd_data;
   logic               wb_fwd_en;
   logic [4:0]         wb_fwd_rd;
   logic [31:0]        wb_fwd_data;
   logic               ex_ready;
   logic               flush;
   logic               ex_valid;
   logic [5:0]         ex_alu_control;
   logic signed [31:0] operand_A, operand_B;
   logic [31:0]        ex_store_data, ex_pc;
   logic [4:0]         ex_rd_addr;
   logic               ex_reg_write, ex_mem_read, ex_mem_write;
   logic [15:0]        lu_stall_cnt;

   int checks   = 0;
   int failures = 0;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_alu_control(id_alu_control), .id_pc(id_pc),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
      .id_use_pc(id_use_pc), .id_use_imm(id_use_imm), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
      .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
      .ex_ready(ex_ready), .flush(flush),
      .ex_valid(ex_valid), .ex_alu_control(ex_alu_control),
      .operand_A(operand_A), .operand_B(operand_B),
      .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd_addr(ex_rd_addr),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .lu_stall_cnt(lu_stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Returns 2 time units after a rising edge, safely between edges.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      id_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
      mem_fwd_en = 1'b0; mem_fwd_rd = 5'd0; mem_fwd_data = 32'd0;
      wb_fwd_en = 1'b0; wb_fwd_rd = 5'd0; wb_fwd_data = 32'd0;
   endtask

   task automatic drive_id(input logic [5:0] alu, input logic [31:0] pc, input logic [31:0] rs1d,
                           input logic [31:0] rs2d, input logic [31:0] imm,
                           input logic [4:0] rs1a, input logic [4:0] rs2a, input logic [4:0] rda,
                           input logic upc, input logic uimm, input logic rw, input logic mr, input logic mw);
      id_valid = 1'b1; id_alu_control = alu; id_pc = pc;
      id_rs1_data = rs1d; id_rs2_data = rs2d; id_imm = imm;
      id_rs1_addr = rs1a; id_rs2_addr = rs2a; id_rd_addr = rda;
      id_use_pc = upc; id_use_imm = uimm; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
   endtask

   // lw x3 enters EX, then a dependent add stalls one cycle and follows it.
   task automatic load_use_event();
      drive_id(6'h00, 32'h500, 32'h1000, 32'h0, 32'h4, 5'd1, 5'd0, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      idle();
      drive_id(6'h01, 32'h504, 32'h2, 32'h0, 32'h0, 5'd2, 5'd3, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      tick();
      idle();
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      drive_id(6'h00, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      id_valid = 1'b0;
      #3;
      chk("rst_ex_valid", ex_valid, 0);
      chk("rst_opA", operand_A, 0);
      chk("rst_opB", operand_B, 0);
      chk("rst_alu", ex_alu_control, 0);
      chk("rst_reg_write", ex_reg_write, 0);
      chk("rst_cnt", lu_stall_cnt, 0);
      chk("rst_id_ready", id_ready, 1);
      #9 rst_n = 1'b1;
      tick();

      // basic transfer, one-cycle latency
      drive_id(6'h01, 32'h100, 32'h11, 32'h22, 32'h4, 5'd1, 5'd2, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      #1;
      chk("xfer_id_ready", id_ready, 1);
      chk("xfer_pre_valid", ex_valid, 0);
      tick();
      idle();
      #1;
      chk("xfer_valid", ex_valid, 1);
      chk("xfer_opA", operand_A, 32'h11);
      chk("xfer_opB", operand_B, 32'h22);
      chk("xfer_store", ex_store_data, 32'h22);
      chk("xfer_rd", ex_rd_addr, 4);
      chk("xfer_pc", ex_pc, 32'h100);
      chk("xfer_alu", ex_alu_control, 1);
      chk("xfer_reg_write", ex_reg_write, 1);
      chk("xfer_mem_read", ex_mem_read, 0);

      // pc / immediate operand select
      drive_id(6'h02, 32'h200, 32'h33, 32'h44, 32'hFFFF_FFF0, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      idle();
      #1;
      chk("sel_opA_pc", operand_A, 32'h200);
      chk("sel_opB_imm", operand_B, 32'hFFFF_FFF0);
      chk("sel_store", ex_store_data, 32'h44);
      chk("sel_mem_write", ex_mem_write, 1);

      // forwarding priority
      drive_id(6'h00, 32'h300, 32'h10, 32'h66, 32'h0, 5'd5, 5'd6, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      idle();
      mem_fwd_en = 1'b1; mem_fwd_rd = 5'd5; mem_fwd_data = 32'hAA;
      wb_fwd_en = 1'b1; wb_fwd_rd = 5'd5; wb_fwd_data = 32'hBB;
      #1 chk("fwd_mem_prio", operand_A, 32'hAA);
      mem_fwd_en = 1'b0;
      #1 chk("fwd_wb", operand_A, 32'hBB);
      wb_fwd_en = 1'b0;
      #1 chk("fwd_none", operand_A, 32'h10);
      wb_fwd_en = 1'b1; wb_fwd_rd = 5'd6; wb_fwd_data = 32'hCC;
      #1;
      chk("fwd_wb_opB", operand_B, 32'hCC);
      chk("fwd_wb_store", ex_store_data, 32'hCC);
      mem_fwd_en = 1'b1; mem_fwd_rd = 5'd6; mem_fwd_data = 32'hDD;
      #1 chk("fwd_mem_opB", operand_B, 32'hDD);
      idle();
      drive_id(6'h00, 32'h300, 32'h77, 32'h66, 32'h0, 5'd0, 5'd6, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      idle();
      mem_fwd_en = 1'b1; mem_fwd_rd = 5'd0; mem_fwd_data = 32'hAA;
      wb_fwd_en = 1'b1; wb_fwd_rd = 5'd0; wb_fwd_data = 32'hBB;
      #1 chk("fwd_x0", operand_A, 32'h0);
      idle();

      // hold refresh keeps forwarded data
      drive_id(6'h00, 32'h400, 32'h01, 32'h02, 32'h0, 5'd7, 5'd8, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      idle();
      ex_ready = 1'b0;
      mem_fwd_en = 1'b1; mem_fwd_rd = 5'd7; mem_fwd_data = 32'h55;
      #1;
      chk("hold_opA_c1", operand_A, 32'h55);
      chk("hold_id_ready", id_ready, 0);
      tick();
      mem_fwd_en = 1'b0;
      #1 chk("hold_opA_c2", operand_A, 32'h55);
      tick();
      #1;
      chk("hold_opA_c3", operand_A, 32'h55);
      chk("hold_valid", ex_valid, 1);
      ex_ready = 1'b1;
      tick();
      #1 chk("hold_release_bubble", ex_valid, 0);

      // load-use stall
      drive_id(6'h00, 32'h500, 32'h1000, 32'h0, 32'h4, 5'd1, 5'd0, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      idle();
      #1 chk("lu_lw_mem_read", ex_mem_read, 1);
      drive_id(6'h01, 32'h504, 32'h2, 32'h0, 32'h0, 5'd2, 5'd3, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      #1;
      chk("lu_id_ready", id_ready, 0);
      chk("lu_cnt_before", lu_stall_cnt, 0);
      tick();
      #1;
      chk("lu_bubble_valid", ex_valid, 0);
      chk("lu_bubble_mem_read", ex_mem_read, 0);
      chk("lu_bubble_reg_write", ex_reg_write, 0);
      chk("lu_cnt_after", lu_stall_cnt, 1);
      chk("lu_id_ready_again", id_ready, 1);
      tick();
      idle();
      mem_fwd_en = 1'b1; mem_fwd_rd = 5'd3; mem_fwd_data = 32'hDEAD_0000;
      #1;
      chk("lu_add_valid", ex_valid, 1);
      chk("lu_add_rd", ex_rd_addr, 9);
      chk("lu_add_opB", operand_B, 32'hDEAD_0000);
      chk("lu_cnt_hold", lu_stall_cnt, 1);
      idle();

      // load to x0 never stalls
      drive_id(6'h00, 32'h600, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      idle();
      drive_id(6'h01, 32'h604, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      #1 chk("lu_x0_id_ready", id_ready, 1);
      idle();

      // flush dominates hold and load-use
      drive_id(6'h00, 32'h700, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      idle();
      drive_id(6'h01, 32'h704, 32'h0, 32'h0, 32'h0, 5'd3, 5'd4, 5'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      ex_ready = 1'b0; flush = 1'b1;
      #1 chk("flush_hold_id_ready", id_ready, 0);
      tick();
      idle();
      #1;
      chk("flush_hold_valid", ex_valid, 0);
      chk("flush_hold_cnt", lu_stall_cnt, 1);
      drive_id(6'h00, 32'h700, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      idle();
      drive_id(6'h01, 32'h704, 32'h0, 32'h0, 32'h0, 5'd3, 5'd4, 5'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      flush = 1'b1;
      #1 chk("flush_adv_id_ready", id_ready, 0);
      tick();
      idle();
      #1;
      chk("flush_adv_valid", ex_valid, 0);
      chk("flush_adv_cnt", lu_stall_cnt, 1);
      load_use_event();
      #1 chk("post_flush_lu_cnt", lu_stall_cnt, 2);

      // saturation from a preloaded count
      force dut.lu_stall_cnt_q = 16'hFFFE;
      #1 release dut.lu_stall_cnt_q;
      #1 chk("sat_preload", lu_stall_cnt, 16'hFFFE);
      load_use_event();
      #1 chk("sat_ffff", lu_stall_cnt, 16'hFFFF);
      load_use_event();
      #1 chk("sat_no_wrap", lu_stall_cnt, 16'hFFFF);

      // asynchronous reset mid-cycle, then immediate resume
      drive_id(6'h03, 32'h800, 32'h1234, 32'h5678, 32'h0, 5'd1, 5'd2, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      idle();
      #1 chk("arst_pre_valid", ex_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_valid", ex_valid, 0);
      chk("arst_cnt", lu_stall_cnt, 0);
      chk("arst_opA", operand_A, 0);
      chk("arst_alu", ex_alu_control, 0);
      #2 rst_n = 1'b1;
      drive_id(6'h04, 32'h900, 32'h4321, 32'h0, 32'h0, 5'd1, 5'd2, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      idle();
      #1;
      chk("resume_valid", ex_valid, 1);
      chk("resume_opA", operand_A, 32'h4321);
      chk("resume_alu", ex_alu_control, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL provide: clk  in  1  single clock, all state rising-edge.
REQ-002 SHALL provide: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL provide: id_valid  in  1 / id_ready  out  1  decode-side handshake.
REQ-004 SHALL provide: id_alu_control  in  6 / id_pc, id_rs1_data, id_rs2_data, id_imm  in  32 each.
REQ-005 SHALL provide: id_rs1_addr, id_rs2_addr, id_rd_addr  in  5 each / id_use_pc, id_use_imm, id_reg_write, id_mem_read, id_mem_write  in  1 each.
REQ-006 SHALL provide: mem_fwd_en  in  1, mem_fwd_rd  in  5, mem_fwd_data  in  32; wb_fwd_en  in  1, wb_fwd_rd  in  5, wb_fwd_data  in  32.
REQ-007 SHALL provide: ex_ready  in  1  downstream accepts EX entry; flush  in  1  kill EX entry (branch/JALR redirect).
REQ-008 SHALL provide: ex_valid  out  1 / ex_alu_control  out  6 / operand_A, operand_B  out  32 signed (ALU operands).
REQ-009 SHALL provide: ex_store_data, ex_pc  out  32 / ex_rd_addr  out  5 / ex_reg_write, ex_mem_read, ex_mem_write  out  1.
REQ-010 SHALL provide: lu_stall_cnt  out  16  saturating load-use stall counter.

Function
REQ-011 SHALL hold one EX entry (ex_valid plus registered fields: alu_control, pc, rs1/rs2 values, imm, addrs, control bits).
REQ-012 advance = !ex_valid | ex_ready; transfer ID->EX occurs when id_valid & id_ready.
REQ-013 load_use = ex_valid & ex_mem_read & ex_rd_addr!=0 & (id_rs1_addr==ex_rd_addr | id_rs2_addr==ex_rd_addr); conservative, both sources always compared.
REQ-014 id_ready = advance & !load_use & !flush (combinational).
REQ-015 Forwarded value fwd(r, addr): addr==0 -> 0; else mem_fwd_en & mem_fwd_rd==addr -> mem_fwd_data; else wb_fwd_en & wb_fwd_rd==addr -> wb_fwd_data; else registered r. MEM priority over WB.
REQ-016 operand_A = use_pc ? ex_pc : fwd(rs1); operand_B = use_imm ? imm : fwd(rs2); ex_store_data = fwd(rs2); all combinational from EX registers, zero added latency.
REQ-017 While ex_valid & !ex_ready & !flush (hold), registered rs1/rs2 values SHALL be overwritten each cycle with fwd(rs1)/fwd(rs2) so forwarded data is not lost when producers retire.
REQ-018 On advance & !flush: transfer -> load ID fields, ex_valid=1; no transfer (id_valid=0 or load_use) -> ex_valid=0 (bubble), other fields don't-care.
REQ-019 flush=1 SHALL clear ex_valid next edge regardless of ex_ready, id_valid or load_use; flush has highest priority.
REQ-020 Ex control outputs ex_reg_write, ex_mem_read, ex_mem_write SHALL be gated by ex_valid (0 when ex_valid=0).
REQ-021 FSM states RUN, LU_STALL: RUN->LU_STALL when load_use & advance & !flush; LU_STALL->RUN unconditionally next cycle (bubble now in EX, load_use false); flush in any state -> RUN.
REQ-022 lu_stall_cnt SHALL increment by 1 on each RUN->LU_STALL transition, saturate at 16'hFFFF, never wrap.
REQ-023 Latency: ID accepted in cycle N appears on ex_* outputs in cycle N+1.

Reset
REQ-024 rst_n=0 SHALL asynchronously force ex_valid=0, all EX registers 0, FSM=RUN, lu_stall_cnt=0; outputs therefore operand_A=operand_B=0, ex_alu_control=0, control bits 0.
REQ-025 Reset deassertion mid-operation SHALL resume with empty EX; first transfer permitted on first edge after rst_n=1.

Verification
REQ-026 Forward priority: EX rs1=5 reg 0x10, mem_fwd(rd5,0xAA) and wb_fwd(rd5,0xBB) -> operand_A=0xAA; mem_fwd off -> 0xBB; rs1=0 with both matching -> 0.
REQ-027 Load-use: EX lw rd=3, ID add rs2=3 -> id_ready=0 one cycle, ex_valid=0 next cycle, lu_stall_cnt 0->1, add enters EX following cycle.
REQ-028 Hold refresh: ex_ready=0 three cycles, mem_fwd(rd7,0x55) only first cycle, EX rs1=7 -> operand_A stays 0x55 after forward drops.
REQ-029 Flush priority: flush=1 with id_valid=1, ex_ready=0, load_use=1 -> id_ready=0, ex_valid=0 next edge, FSM=RUN, counter unchanged.
REQ-030 Saturation/reset: preload 0xFFFE load-use events -> two more events give 0xFFFF; async rst_n low mid-cycle -> ex_valid=0 and counter=0 immediately, before next clk edge.
